// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: sequential PC generation, branch/exception redirect,
// single-outstanding SRAM-like instruction port, and delivery to the ID buffer.
module if_fetch_ctrl #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'hbfc00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_flush,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic [31:0]       IF_inst,
    output logic [ADDR_W-1:0] IF_PC,
    output logic              IF_invalid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_reg, pc_nxt;
    logic              discard, discard_nxt;
    logic [ADDR_W-1:0] flush_tgt, flush_tgt_nxt;
    logic              pend_br, pend_br_nxt;
    logic [ADDR_W-1:0] br_tgt_reg, br_tgt_nxt;
    logic [31:0]       hold_inst, hold_inst_nxt;
    logic [ADDR_W-1:0] hold_pc, hold_pc_nxt;

    logic              fresh_valid;
    logic              held_valid;
    logic              accept;
    logic [ADDR_W-1:0] pc_adv;

    // A flush in the same cycle masks whatever would otherwise be offered to ID.
    assign fresh_valid = (state == WAIT) && inst_data_ok && !discard && !exc_flush;
    assign held_valid  = (state == HOLD) && !exc_flush;
    assign accept      = (fresh_valid || held_valid) && !ID_stall;

    // A branch resolved in the acceptance cycle itself wins over the pending one.
    assign pc_adv = br_taken ? br_target :
                    pend_br  ? br_tgt_reg :
                               pc_reg + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc_reg     <= RESET_PC;
            discard    <= 1'b0;
            flush_tgt  <= RESET_PC;
            pend_br    <= 1'b0;
            br_tgt_reg <= '0;
            hold_inst  <= '0;
            hold_pc    <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            discard    <= discard_nxt;
            flush_tgt  <= flush_tgt_nxt;
            pend_br    <= pend_br_nxt;
            br_tgt_reg <= br_tgt_nxt;
            hold_inst  <= hold_inst_nxt;
            hold_pc    <= hold_pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_reg;
        discard_nxt   = discard;
        flush_tgt_nxt = flush_tgt;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;

        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (exc_flush) pc_nxt = exc_target;
            end
            REQ: begin
                // pc_reg drives inst_addr and must stay stable, so a flush target is parked.
                if (exc_flush) begin
                    discard_nxt   = 1'b1;
                    flush_tgt_nxt = exc_target;
                end
                if (inst_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (exc_flush || discard) begin
                        state_nxt   = REQ;
                        discard_nxt = 1'b0;
                        pc_nxt      = exc_flush ? exc_target : flush_tgt;
                    end else if (ID_stall) begin
                        state_nxt     = HOLD;
                        hold_inst_nxt = inst_rdata;
                        hold_pc_nxt   = pc_reg;
                    end else begin
                        state_nxt = REQ;
                        pc_nxt    = pc_adv;
                    end
                end else if (exc_flush) begin
                    discard_nxt   = 1'b1;
                    flush_tgt_nxt = exc_target;
                end
            end
            HOLD: begin
                if (exc_flush) begin
                    state_nxt = REQ;
                    pc_nxt    = exc_target;
                end else if (!ID_stall) begin
                    state_nxt = REQ;
                    pc_nxt    = pc_adv;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pend_br_nxt = pend_br;
        br_tgt_nxt  = br_tgt_reg;
        if (exc_flush) begin
            pend_br_nxt = 1'b0;
        end else if (accept) begin
            pend_br_nxt = 1'b0;
        end else if (br_taken) begin
            pend_br_nxt = 1'b1;
            br_tgt_nxt  = br_target;
        end
    end

    always_comb begin
        inst_req   = (state == REQ);
        inst_addr  = pc_reg;
        IF_invalid = 1'b1;
        IF_inst    = '0;
        IF_PC      = RESET_PC;
        if (held_valid) begin
            IF_invalid = 1'b0;
            IF_inst    = hold_inst;
            IF_PC      = hold_pc;
        end else if (fresh_valid) begin
            IF_invalid = 1'b0;
            IF_inst    = inst_rdata;
            IF_PC      = pc_reg;
        end
    end

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = '0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: transaction-level fetch model with a randomized
// SRAM-like slave, plus directed scenarios pinned by literal expectations.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RPC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst, ID_stall, br_taken, exc_flush;
    logic [31:0] br_target, exc_target;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] IF_inst, IF_PC;
    logic        IF_invalid;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .ID_stall(ID_stall),
        .br_taken(br_taken), .br_target(br_target),
        .exc_flush(exc_flush), .exc_target(exc_target),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .IF_inst(IF_inst), .IF_PC(IF_PC), .IF_invalid(IF_invalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus knobs
    logic        s_rst = 1'b1, s_stall = 1'b0, s_br = 1'b0, s_fl = 1'b0;
    logic [31:0] s_brt = '0, s_flt = '0;
    int          p_aok = 100, p_dok = 100;
    logic        force_en = 1'b0;
    logic [31:0] force_rdata = '0;

    // slave side
    logic        slave_busy = 1'b0;
    logic        hs_now;

    // transaction-level model: a fetch pointer, one in-flight read, one buffered
    // instruction, a remembered branch target and a remembered flush target
    logic        m_known = 1'b0, m_started, m_issued, m_drop, m_buf_v, m_br_v;
    logic [31:0] m_fetch_pc, m_redirect, m_buf_inst, m_buf_pc, m_br_pc;
    logic        e_req, e_inv;
    logic [31:0] e_inst, e_pc;

    // observation logs
    logic [31:0] acc_q[$];
    int          req_cycles = 0;
    int          val_cycles = 0;

    task automatic model_outputs();
        e_req  = m_started && !m_issued && !m_buf_v;
        e_inv  = 1'b1;
        e_inst = '0;
        e_pc   = RPC;
        if (m_buf_v && !exc_flush) begin
            e_inv = 1'b0; e_inst = m_buf_inst; e_pc = m_buf_pc;
        end else if (m_issued && inst_data_ok && !m_drop && !exc_flush) begin
            e_inv = 1'b0; e_inst = inst_rdata; e_pc = m_fetch_pc;
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        rst          = s_rst;
        ID_stall     = s_stall;
        br_taken     = s_br;
        br_target    = s_brt;
        exc_flush    = s_fl;
        exc_target   = s_flt;
        inst_addr_ok = ($urandom_range(99) < p_aok);
        inst_data_ok = slave_busy && ($urandom_range(99) < p_dok);
        inst_rdata   = force_en ? force_rdata : $urandom;
        #1;
        if (m_known) begin
            model_outputs();
            chk("inst_req", inst_req, e_req);
            if (e_req) chk("inst_addr", inst_addr, m_fetch_pc);
            chk("IF_invalid", IF_invalid, e_inv);
            chk("IF_inst", IF_inst, e_inst);
            chk("IF_PC", IF_PC, e_pc);
            chk("tie_off", {inst_wr, inst_size, inst_wdata[28:0]}, 32'h4000_0000);
        end
        if (inst_req && inst_addr_ok) acc_q.push_back(inst_addr);
        if (inst_req) req_cycles++;
        if (!IF_invalid) val_cycles++;
        hs_now = inst_req && inst_addr_ok;
    endtask

    task automatic end_cycle();
        logic [31:0] nxt;
        logic        accept;
        @(posedge clk);
        if (rst) slave_busy = 1'b0;
        else begin
            if (inst_data_ok) slave_busy = 1'b0;
            if (hs_now) slave_busy = 1'b1;
        end
        if (rst) begin
            m_known = 1'b1; m_started = 1'b0; m_fetch_pc = RPC; m_issued = 1'b0;
            m_drop = 1'b0; m_buf_v = 1'b0; m_br_v = 1'b0;
        end else if (m_known) begin
            accept = !e_inv && !ID_stall;
            nxt = br_taken ? br_target : (m_br_v ? m_br_pc : e_pc + 32'd4);
            if (!m_started) begin
                m_started = 1'b1;
                if (exc_flush) m_fetch_pc = exc_target;
            end else if (m_buf_v) begin
                if (exc_flush) begin m_buf_v = 1'b0; m_fetch_pc = exc_target; end
                else if (!ID_stall) begin m_buf_v = 1'b0; m_fetch_pc = nxt; end
            end else if (m_issued) begin
                if (inst_data_ok) begin
                    m_issued = 1'b0;
                    if (exc_flush) begin m_drop = 1'b0; m_fetch_pc = exc_target; end
                    else if (m_drop) begin m_drop = 1'b0; m_fetch_pc = m_redirect; end
                    else if (ID_stall) begin
                        m_buf_v = 1'b1; m_buf_inst = inst_rdata; m_buf_pc = m_fetch_pc;
                    end else m_fetch_pc = nxt;
                end else if (exc_flush) begin
                    m_drop = 1'b1; m_redirect = exc_target;
                end
            end else begin
                if (exc_flush) begin m_drop = 1'b1; m_redirect = exc_target; end
                if (inst_addr_ok) m_issued = 1'b1;
            end
            if (exc_flush || accept) m_br_v = 1'b0;
            else if (br_taken) begin m_br_v = 1'b1; m_br_pc = br_target; end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic quiet();
        s_rst = 1'b0; s_stall = 1'b0; s_br = 1'b0; s_fl = 1'b0;
        p_aok = 100; p_dok = 100; force_en = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        s_rst = 1'b1;
        run(1);
        s_rst = 1'b0;
        acc_q.delete();
        req_cycles = 0;
        val_cycles = 0;
    endtask

    initial begin
        // zero-latency slave after reset
        do_reset();
        begin_cycle();
        chk("rst_req", inst_req, 0);
        chk("rst_invalid", IF_invalid, 1);
        chk("rst_addr", inst_addr, RPC);
        chk("rst_pc", IF_PC, RPC);
        chk("rst_inst", IF_inst, 0);
        end_cycle();
        run(6);
        chk("seq_count", acc_q.size(), 3);
        chk("seq_a0", acc_q[0], 32'hbfc00000);
        chk("seq_a1", acc_q[1], 32'hbfc00004);
        chk("seq_a2", acc_q[2], 32'hbfc00008);
        chk("seq_valid_cycles", val_cycles, 3);

        // addr_ok withheld for three cycles
        do_reset();
        p_aok = 0;
        run(4);
        p_aok = 100;
        run(2);
        chk("held_req_cycles", req_cycles, 4);
        chk("held_accepts", acc_q.size(), 1);
        chk("held_addr", acc_q[0], 32'hbfc00000);
        chk("held_valid_cycles", val_cycles, 1);

        // ID stall spanning data_ok
        do_reset();
        run(2);
        s_stall = 1'b1; force_en = 1'b1; force_rdata = 32'h24020001;
        for (int i = 0; i < 2; i++) begin
            begin_cycle();
            chk("stall_inst", IF_inst, 32'h24020001);
            chk("stall_valid", IF_invalid, 0);
            chk("stall_no_req", inst_req, 0);
            end_cycle();
            force_en = 1'b0;
        end
        s_stall = 1'b0;
        begin_cycle();
        chk("stall_release_inst", IF_inst, 32'h24020001);
        chk("stall_release_pc", IF_PC, 32'hbfc00000);
        end_cycle();
        begin_cycle();
        chk("stall_next_addr", inst_addr, 32'hbfc00004);
        chk("stall_next_req", inst_req, 1);
        end_cycle();

        // branch with delay slot, then exception, then flush+branch, then reset mid-WAIT
        do_reset();
        run(6);
        p_dok = 0; s_br = 1'b1; s_brt = 32'hbfc00100;
        run(1);
        p_dok = 100; s_br = 1'b0;
        begin_cycle();
        chk("br_slot_valid", IF_invalid, 0);
        chk("br_slot_pc", IF_PC, 32'hbfc00008);
        end_cycle();
        begin_cycle();
        chk("br_target_addr", inst_addr, 32'hbfc00100);
        end_cycle();
        p_dok = 0; s_fl = 1'b1; s_flt = 32'hbfc00380;
        run(1);
        p_dok = 100; s_fl = 1'b0;
        begin_cycle();
        chk("exc_drop_invalid", IF_invalid, 1);
        end_cycle();
        begin_cycle();
        chk("exc_target_addr", inst_addr, 32'hbfc00380);
        end_cycle();
        p_dok = 0; s_fl = 1'b1; s_br = 1'b1; s_flt = 32'hbfc00380; s_brt = 32'hbfc00100;
        run(1);
        p_dok = 100; s_fl = 1'b0; s_br = 1'b0;
        run(1);
        begin_cycle();
        chk("exc_over_br_addr", inst_addr, 32'hbfc00380);
        end_cycle();
        p_dok = 0; s_rst = 1'b1;
        run(1);
        s_rst = 1'b0; p_dok = 100;
        begin_cycle();
        chk("midrst_no_req", inst_req, 0);
        end_cycle();
        begin_cycle();
        chk("midrst_restart", inst_addr, RPC);
        chk("midrst_restart_req", inst_req, 1);
        end_cycle();

        // randomized traffic, including wrap-around targets
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0) begin
                p_aok = 20 + $urandom_range(80);
                p_dok = 20 + $urandom_range(80);
            end
            s_rst   = ($urandom_range(999) < 4);
            s_stall = ($urandom_range(99) < 35);
            s_br    = ($urandom_range(99) < 12);
            s_fl    = ($urandom_range(99) < 6);
            case ($urandom_range(3))
                0:       s_brt = 32'hfffffff8;
                1:       s_brt = $urandom;
                default: s_brt = {$urandom_range(32'h3fffffff), 2'b00};
            endcase
            s_flt = ($urandom_range(3) == 0) ? 32'hfffffffc : {$urandom_range(32'h3fffffff), 2'b00};
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
